// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // One-hot-low anode pattern for the digit being driven.
  function automatic logic [7:0] an_select(input logic [2:0] idx);
    an_select = ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex-to-segment decoder; all sixteen codes are shown as hex digits.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan8.sv
// Eight-digit time-multiplexed seven-segment driver with a blanking interval at the
// start of every slot and a frame-coherent snapshot of the digit inputs.
module seg_scan8
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 100,
  parameter int DEAD_TICKS  = 4
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [3:0] I_num1,
  input  logic [3:0] I_num2,
  input  logic [3:0] I_num3,
  input  logic [3:0] I_num4,
  input  logic [3:0] I_num5,
  input  logic [3:0] I_num6,
  input  logic [3:0] I_num7,
  input  logic [3:0] I_num8,
  input  logic [7:0] I_blank,
  input  logic [7:0] I_dp,
  output logic [7:0] O_an,
  output logic [6:0] O_seg,
  output logic       O_dp,
  output logic       O_frame
);

  localparam int CW = $clog2(DIGIT_TICKS);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] DEAD_END  = CW'(DEAD_TICKS);

  logic [CW-1:0]   slot_cnt;
  logic [CW-1:0]   slot_cnt_next;
  logic [2:0]      digit_idx;
  scan_state_t     state;
  scan_state_t     state_next;

  logic [7:0][3:0] snap_num;
  logic [7:0]      snap_blank;
  logic [7:0]      snap_dp;

  logic            frame_start;
  logic [6:0]      dec_seg;
  logic [7:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;

  assign frame_start   = (slot_cnt == '0) && (digit_idx == 3'd0);
  assign slot_cnt_next = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + CW'(1);

  // Slot counter and digit index; the index wraps 7->0 with no idle slot.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      slot_cnt  <= '0;
      digit_idx <= 3'd0;
    end else begin
      slot_cnt <= slot_cnt_next;
      if (slot_cnt == SLOT_LAST)
        digit_idx <= digit_idx + 3'd1;
    end
  end

  // Inputs are sampled only at the first edge of slot 0 so a frame never mixes old and new digits.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      snap_num   <= '0;
      snap_blank <= '0;
      snap_dp    <= '0;
    end else if (frame_start) begin
      snap_num   <= {I_num8, I_num7, I_num6, I_num5, I_num4, I_num3, I_num2, I_num1};
      snap_blank <= I_blank;
      snap_dp    <= I_dp;
    end
  end

  // State tracks the position of the current edge within its slot.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst)
      state <= BLANK;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = DRIVE;
    if (slot_cnt_next < DEAD_END)
      state_next = BLANK;
  end

  seg_hex_dec u_dec (
    .value (snap_num[digit_idx]),
    .seg   (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state == DRIVE) begin
      an_d  = an_select(digit_idx);
      seg_d = snap_blank[digit_idx] ? SEG_OFF : dec_seg;
      dp_d  = ~snap_dp[digit_idx];
    end
  end

  // Every output is registered so the pins never see a combinational path from the inputs.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      O_an    <= AN_OFF;
      O_seg   <= SEG_OFF;
      O_dp    <= 1'b1;
      O_frame <= 1'b0;
    end else begin
      O_an    <= an_d;
      O_seg   <= seg_d;
      O_dp    <= dp_d;
      O_frame <= frame_start;
    end
  end

endmodule
